sram_2rw_param: RTL and testbench

Parametrised, single-clock, two-read/write-port behavioural SRAM model. It generalises the fixed 32x33 2RW macro model to arbitrary width and depth and adds:
- per-bit write masks;
- a selectable same-port read-during-write mode;
- a defined cross-port collision policy with sticky flags;
- an optional output register stage with read-valid strobes.

It sits in the tech SRAM cache as the simulation/synthesis stand-in for generated 2RW macros.

---
 rtl/sram_2rw_pkg.sv | 24 ++
 rtl/sram_2rw_rdpipe.sv | 61 ++++++
 rtl/sram_2rw_param.sv | 139 +++++++++++++
 tb/tb_sram_2rw_param.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_2rw_pkg.sv
// Shared types and helpers for the parametrised 2RW SRAM model.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package sram_2rw_pkg;

  // Same-port read-during-write behaviour.
  typedef enum logic {
    RW_READ_FIRST  = 1'b0,
    RW_WRITE_FIRST = 1'b1
  } rw_mode_e;

  // Widest word the model supports; callers zero-extend into this width.
  localparam int MAX_WIDTH = 256;

  // Bits with mask=1 take data, all others keep the old value.
  function automatic logic [MAX_WIDTH-1:0] merge_mask(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] data_word,
    input logic [MAX_WIDTH-1:0] mask_word
  );
    return (old_word & ~mask_word) | (data_word & mask_word);
  endfunction

endpackage

// File: rtl/sram_2rw_rdpipe.sv
// Read-data output stage for one SRAM port: registers raw read data and its valid.
// Latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from the sampling edge.
// Backpressure: none; accepts a read every cycle, output holds when no read completes.
//
// Ports:
//   clk, rst     clock and async active-high reset (flushes all stages)
//   rd_vld       a read was sampled this cycle
//   rd_dat       raw word for that read (pre-merged for read mode, zero when out of range)
//   o, ov        read data and one-cycle valid pulse
module sram_2rw_rdpipe #(
  parameter int WIDTH   = 33,
  parameter int OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_vld,
  input  logic [WIDTH-1:0] rd_dat,
  output logic [WIDTH-1:0] o,
  output logic             ov
);

  logic [WIDTH-1:0] s1_dat;
  logic             s1_vld;

  // First stage always present: data only updates on a real read so o holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_dat <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= rd_vld;
      if (rd_vld) begin
        s1_dat <= rd_dat;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] s2_dat;
    logic             s2_vld;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_dat <= '0;
        s2_vld <= 1'b0;
      end else begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_dat <= s1_dat;
        end
      end
    end

    assign o  = s2_dat;
    assign ov = s2_vld;
  end else begin : g_no_out_reg
    assign o  = s1_dat;
    assign ov = s1_vld;
  end

endmodule

// File: rtl/sram_2rw_param.sv
// Parametrised single-clock two-read/write-port SRAM model with masks and sticky error flags.
// Latency: reads 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); writes visible to reads on the next edge.
// Backpressure: none; both ports accept a read and/or write every cycle.
//
// Ports:
//   CE, RST               clock and async active-high reset
//   CSBn/WEBn/OEBn        per-port active-low chip select, write enable, read enable
//   An, In, WMn           per-port address, write data, write bit mask (1 = bit written)
//   On, OVn               per-port read data and one-cycle read-valid pulse
//   COLL                  sticky: both ports wrote one address with overlapping masks
//   OOR                   sticky: an access used an address >= DEPTH
module sram_2rw_param
  import sram_2rw_pkg::*;
#(
  parameter int       WIDTH   = 33,
  parameter int       DEPTH   = 32,
  parameter int       ADDR_W  = $clog2(DEPTH),
  parameter int       OUT_REG = 0,
  parameter rw_mode_e RW_MODE = RW_READ_FIRST
) (
  input  logic              CE,
  input  logic              RST,
  input  logic              CSB1,
  input  logic              WEB1,
  input  logic              OEB1,
  input  logic [ADDR_W-1:0] A1,
  input  logic [WIDTH-1:0]  I1,
  input  logic [WIDTH-1:0]  WM1,
  output logic [WIDTH-1:0]  O1,
  output logic              OV1,
  input  logic              CSB2,
  input  logic              WEB2,
  input  logic              OEB2,
  input  logic [ADDR_W-1:0] A2,
  input  logic [WIDTH-1:0]  I2,
  input  logic [WIDTH-1:0]  WM2,
  output logic [WIDTH-1:0]  O2,
  output logic              OV2,
  output logic              COLL,
  output logic              OOR
);

  function automatic logic [WIDTH-1:0] merge_w(
    input logic [WIDTH-1:0] old_word,
    input logic [WIDTH-1:0] data_word,
    input logic [WIDTH-1:0] mask_word
  );
    return WIDTH'(merge_mask(MAX_WIDTH'(old_word), MAX_WIDTH'(data_word), MAX_WIDTH'(mask_word)));
  endfunction

  // Array is deliberately not reset; contents are whatever the tool starts with.
  logic [WIDTH-1:0] mem [DEPTH];

  logic in_rng1, in_rng2;

  // A power-of-two depth cannot be exceeded by the address bus.
  if (DEPTH == (1 << ADDR_W)) begin : g_pow2
    assign in_rng1 = 1'b1;
    assign in_rng2 = 1'b1;
  end else begin : g_npow2
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    assign in_rng1 = ({1'b0, A1} < DEPTH_X);
    assign in_rng2 = ({1'b0, A2} < DEPTH_X);
  end

  logic             re1, re2, we1, we2, acc1, acc2;
  logic             same_addr, both_wr;
  logic [WIDTH-1:0] old1, old2, wdat1, wdat2, wboth;
  logic [WIDTH-1:0] rd1, rd2;

  assign re1  = ~CSB1 & ~OEB1;
  assign re2  = ~CSB2 & ~OEB2;
  assign we1  = ~CSB1 & ~WEB1 & in_rng1;
  assign we2  = ~CSB2 & ~WEB2 & in_rng2;
  assign acc1 = ~CSB1 & (~WEB1 | ~OEB1);
  assign acc2 = ~CSB2 & (~WEB2 | ~OEB2);

  // Out-of-range lookups read as zero.
  assign old1 = in_rng1 ? mem[A1] : '0;
  assign old2 = in_rng2 ? mem[A2] : '0;

  assign wdat1 = merge_w(old1, I1, WM1);
  assign wdat2 = merge_w(old2, I2, WM2);

  // Same-address dual write: apply port 2 first, then port 1 on top so port 1 wins overlaps.
  assign same_addr = (A1 == A2);
  assign both_wr   = we1 & we2 & same_addr;
  assign wboth     = merge_w(wdat2, I1, WM1);

  // Write-first only affects the port's own write; cross-port reads always see the old word.
  always_comb begin
    rd1 = old1;
    rd2 = old2;
    if (RW_MODE == RW_WRITE_FIRST) begin
      if (we1) rd1 = both_wr ? wboth : wdat1;
      if (we2) rd2 = both_wr ? wboth : wdat2;
    end
  end

  always_ff @(posedge CE) begin
    if (!RST) begin
      if (both_wr) begin
        mem[A1] <= wboth;
      end else begin
        if (we1) mem[A1] <= wdat1;
        if (we2) mem[A2] <= wdat2;
      end
    end
  end

  always_ff @(posedge CE or posedge RST) begin
    if (RST) begin
      COLL <= 1'b0;
      OOR  <= 1'b0;
    end else begin
      if (both_wr && ((WM1 & WM2) != '0)) COLL <= 1'b1;
      if ((acc1 & ~in_rng1) | (acc2 & ~in_rng2)) OOR <= 1'b1;
    end
  end

  sram_2rw_rdpipe #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_rdpipe1 (
    .clk    (CE),
    .rst    (RST),
    .rd_vld (re1),
    .rd_dat (rd1),
    .o      (O1),
    .ov     (OV1)
  );

  sram_2rw_rdpipe #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_rdpipe2 (
    .clk    (CE),
    .rst    (RST),
    .rd_vld (re2),
    .rd_dat (rd2),
    .o      (O2),
    .ov     (OV2)
  );

endmodule

// File: tb/tb_sram_2rw_param.sv
// Directed bench: two instances share stimulus.
//   dut_a: DEPTH=32, OUT_REG=0, read-first   (latency 1)
//   dut_b: DEPTH=24, OUT_REG=1, write-first  (latency 2)
module tb_sram_2rw_param;
  import sram_2rw_pkg::*;

  localparam int W  = 33;
  localparam int AW = 5;

  logic          ce = 1'b0;
  logic          rst = 1'b1;
  logic          csb1, web1, oeb1, csb2, web2, oeb2;
  logic [AW-1:0] a1, a2;
  logic [W-1:0]  i1, i2, wm1, wm2;

  logic [W-1:0]  o1_a, o2_a, o1_b, o2_b;
  logic          ov1_a, ov2_a, ov1_b, ov2_b;
  logic          coll_a, oor_a, coll_b, oor_b;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [W-1:0] ONES  = '1;
  localparam logic [W-1:0] V5    = 33'h1_2345_6789;

  always #5 ce = ~ce;

  sram_2rw_param #(.WIDTH(W), .DEPTH(32), .OUT_REG(0), .RW_MODE(RW_READ_FIRST)) dut_a (
    .CE(ce), .RST(rst),
    .CSB1(csb1), .WEB1(web1), .OEB1(oeb1), .A1(a1), .I1(i1), .WM1(wm1), .O1(o1_a), .OV1(ov1_a),
    .CSB2(csb2), .WEB2(web2), .OEB2(oeb2), .A2(a2), .I2(i2), .WM2(wm2), .O2(o2_a), .OV2(ov2_a),
    .COLL(coll_a), .OOR(oor_a)
  );

  sram_2rw_param #(.WIDTH(W), .DEPTH(24), .OUT_REG(1), .RW_MODE(RW_WRITE_FIRST)) dut_b (
    .CE(ce), .RST(rst),
    .CSB1(csb1), .WEB1(web1), .OEB1(oeb1), .A1(a1), .I1(i1), .WM1(wm1), .O1(o1_b), .OV1(ov1_b),
    .CSB2(csb2), .WEB2(web2), .OEB2(oeb2), .A2(a2), .I2(i2), .WM2(wm2), .O2(o2_b), .OV2(ov2_b),
    .COLL(coll_b), .OOR(oor_b)
  );

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge ce);
    #1;
  endtask

  task automatic set_idle();
    csb1 = 1'b1; web1 = 1'b1; oeb1 = 1'b1; a1 = '0; i1 = '0; wm1 = '0;
    csb2 = 1'b1; web2 = 1'b1; oeb2 = 1'b1; a2 = '0; i2 = '0; wm2 = '0;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
    csb1 = 1'b0; web1 = 1'b0; a1 = a; i1 = d; wm1 = m;
  endtask

  task automatic wr2(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
    csb2 = 1'b0; web2 = 1'b0; a2 = a; i2 = d; wm2 = m;
  endtask

  task automatic rd1(input logic [AW-1:0] a);
    csb1 = 1'b0; oeb1 = 1'b0; a1 = a;
  endtask

  task automatic rd2(input logic [AW-1:0] a);
    csb2 = 1'b0; oeb2 = 1'b0; a2 = a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    cyc(); cyc();
    n_checks++; if (o1_a !== '0) begin n_fail++; $display("FAIL reset_o1_a got %h expected 0", o1_a); end
    n_checks++; if (o2_b !== '0) begin n_fail++; $display("FAIL reset_o2_b got %h expected 0", o2_b); end
    n_checks++; if ({ov1_a, ov2_a, ov1_b, ov2_b} !== 4'b0) begin n_fail++; $display("FAIL reset_ov got %b expected 0000", {ov1_a, ov2_a, ov1_b, ov2_b}); end
    n_checks++; if ({coll_a, oor_a, coll_b, oor_b} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b expected 0000", {coll_a, oor_a, coll_b, oor_b}); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_write_read();
    wr1(5'd5, V5, ONES);
    cyc();
    set_idle();
    rd2(5'd5);
    cyc();
    set_idle();
    n_checks++; if (o2_a !== V5 || ov2_a !== 1'b1) begin n_fail++; $display("FAIL wr_rd_a got %h/%b expected %h/1", o2_a, ov2_a, V5); end
    n_checks++; if (ov2_b !== 1'b0) begin n_fail++; $display("FAIL wr_rd_b_early_ov got %b expected 0", ov2_b); end
    cyc();
    n_checks++; if (o2_a !== V5 || ov2_a !== 1'b0) begin n_fail++; $display("FAIL wr_rd_a_hold got %h/%b expected %h/0", o2_a, ov2_a, V5); end
    n_checks++; if (o2_b !== V5 || ov2_b !== 1'b1) begin n_fail++; $display("FAIL wr_rd_b got %h/%b expected %h/1", o2_b, ov2_b, V5); end
  endtask

  task automatic test_masked();
    wr1(5'd3, '0, ONES);
    cyc();
    wr1(5'd3, ONES, 33'h0_0000_00FF);
    cyc();
    set_idle();
    rd1(5'd3);
    cyc();
    set_idle();
    n_checks++; if (o1_a !== 33'hFF) begin n_fail++; $display("FAIL masked_a got %h expected 0ff", o1_a); end
    cyc();
    n_checks++; if (o1_b !== 33'hFF) begin n_fail++; $display("FAIL masked_b got %h expected 0ff", o1_b); end
  endtask

  task automatic test_back_to_back();
    rd1(5'd5);
    cyc();
    rd1(5'd3);
    n_checks++; if (o1_a !== V5 || ov1_a !== 1'b1) begin n_fail++; $display("FAIL b2b_a0 got %h/%b expected %h/1", o1_a, ov1_a, V5); end
    cyc();
    set_idle();
    n_checks++; if (o1_a !== 33'hFF || ov1_a !== 1'b1) begin n_fail++; $display("FAIL b2b_a1 got %h/%b expected 0ff/1", o1_a, ov1_a); end
    n_checks++; if (o1_b !== V5 || ov1_b !== 1'b1) begin n_fail++; $display("FAIL b2b_b0 got %h/%b expected %h/1", o1_b, ov1_b, V5); end
    cyc();
    n_checks++; if (o1_b !== 33'hFF || ov1_b !== 1'b1) begin n_fail++; $display("FAIL b2b_b1 got %h/%b expected 0ff/1", o1_b, ov1_b); end
    cyc();
  endtask

  task automatic test_rw_mode();
    wr1(5'd7, 33'hAA, ONES);
    cyc();
    wr1(5'd7, 33'h55, ONES);
    oeb1 = 1'b0;
    rd2(5'd7);
    cyc();
    set_idle();
    n_checks++; if (o1_a !== 33'hAA) begin n_fail++; $display("FAIL rw_read_first_o1 got %h expected 0aa", o1_a); end
    n_checks++; if (o2_a !== 33'hAA) begin n_fail++; $display("FAIL rw_cross_a_o2 got %h expected 0aa", o2_a); end
    cyc();
    n_checks++; if (o1_b !== 33'h55) begin n_fail++; $display("FAIL rw_write_first_o1 got %h expected 055", o1_b); end
    n_checks++; if (o2_b !== 33'hAA) begin n_fail++; $display("FAIL rw_cross_b_o2 got %h expected 0aa", o2_b); end
    rd1(5'd7);
    cyc();
    set_idle();
    n_checks++; if (o1_a !== 33'h55) begin n_fail++; $display("FAIL rw_committed got %h expected 055", o1_a); end
    cyc();
  endtask

  task automatic test_collision();
    wr1(5'd9, '0, ONES);
    cyc();
    // Disjoint masks: merge without collision.
    wr1(5'd9, 33'hF0, 33'hF0);
    wr2(5'd9, 33'h0F, 33'h0F);
    cyc();
    set_idle();
    n_checks++; if (coll_a !== 1'b0 || coll_b !== 1'b0) begin n_fail++; $display("FAIL coll_disjoint got %b%b expected 00", coll_a, coll_b); end
    // Overlapping masks.
    wr1(5'd9, 33'hF0, 33'hF0);
    wr2(5'd9, 33'h0F, 33'hFF);
    cyc();
    set_idle();
    n_checks++; if (coll_a !== 1'b1 || coll_b !== 1'b1) begin n_fail++; $display("FAIL coll_overlap got %b%b expected 11", coll_a, coll_b); end
    rd1(5'd9);
    cyc();
    set_idle();
    n_checks++; if (o1_a !== 33'hFF) begin n_fail++; $display("FAIL coll_merge got %h expected 0ff", o1_a); end
    // Port 1 wins overlapping bits.
    wr1(5'd9, 33'h00, 33'hF0);
    wr2(5'd9, 33'hFF, 33'hFF);
    cyc();
    set_idle();
    rd1(5'd9);
    cyc();
    set_idle();
    n_checks++; if (o1_a !== 33'h0F) begin n_fail++; $display("FAIL coll_priority got %h expected 00f", o1_a); end
    // Non-overlapping repeat: flag is sticky.
    wr1(5'd9, 33'hF0, 33'hF0);
    wr2(5'd9, 33'h0F, 33'h0F);
    cyc();
    set_idle();
    cyc();
    n_checks++; if (coll_a !== 1'b1) begin n_fail++; $display("FAIL coll_sticky got %b expected 1", coll_a); end
  endtask

  task automatic test_oor();
    wr1(5'd30, 33'h123, ONES);
    cyc();
    set_idle();
    n_checks++; if (oor_b !== 1'b1 || oor_a !== 1'b0) begin n_fail++; $display("FAIL oor_flag got a=%b b=%b expected a=0 b=1", oor_a, oor_b); end
    rd2(5'd30);
    cyc();
    set_idle();
    n_checks++; if (o2_a !== 33'h123 || ov2_a !== 1'b1) begin n_fail++; $display("FAIL oor_inrange_a got %h/%b expected 123/1", o2_a, ov2_a); end
    cyc();
    n_checks++; if (o2_b !== '0 || ov2_b !== 1'b1) begin n_fail++; $display("FAIL oor_read_b got %h/%b expected 0/1", o2_b, ov2_b); end
    cyc();
    n_checks++; if (oor_b !== 1'b1) begin n_fail++; $display("FAIL oor_sticky got %b expected 1", oor_b); end
  endtask

  task automatic test_reset_flush();
    rd1(5'd5);
    cyc();
    set_idle();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (o1_a !== '0 || ov1_a !== 1'b0) begin n_fail++; $display("FAIL flush_a got %h/%b expected 0/0", o1_a, ov1_a); end
    n_checks++; if (o1_b !== '0 || ov1_b !== 1'b0) begin n_fail++; $display("FAIL flush_b got %h/%b expected 0/0", o1_b, ov1_b); end
    n_checks++; if ({coll_a, oor_b} !== 2'b00) begin n_fail++; $display("FAIL flush_flags got %b expected 00", {coll_a, oor_b}); end
    // Writes and reads during reset must not take effect.
    wr2(5'd5, '0, ONES);
    rd1(5'd5);
    cyc(); cyc();
    set_idle();
    rst = 1'b0;
    cyc();
    n_checks++; if ({ov1_a, ov1_b, ov2_a, ov2_b} !== 4'b0) begin n_fail++; $display("FAIL flush_no_ov got %b expected 0000", {ov1_a, ov1_b, ov2_a, ov2_b}); end
    cyc();
    n_checks++; if (ov1_b !== 1'b0) begin n_fail++; $display("FAIL flush_no_late_ov got %b expected 0", ov1_b); end
    rd1(5'd5);
    cyc();
    set_idle();
    n_checks++; if (o1_a !== V5) begin n_fail++; $display("FAIL retain_a got %h expected %h", o1_a, V5); end
    cyc();
    n_checks++; if (o1_b !== V5) begin n_fail++; $display("FAIL retain_b got %h expected %h", o1_b, V5); end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_write_read();
    test_masked();
    test_back_to_back();
    test_rw_mode();
    test_collision();
    test_oor();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout after 50000 time units");
    $fatal(1, "timeout");
  end

endmodule
